uart_tx_feeder: RTL and testbench

//  Byte buffer and launch controller directly upstream of UART_TX.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_feeder.sv | 101 ++++++++++
 tb/tb_uart_tx_feeder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width and the feeder FSM state encoding.
// Also used by UART_TX and the RX path.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/count.
// Read data is registered and becomes valid the cycle after a pop.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Qualify with the registered flags so a pop never frees a slot for a same-cycle push.
    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && !r_empty;
    assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_push} - {{ADDR_WIDTH{1'b0}}, w_pop};

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_data   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_data   <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == (ADDR_WIDTH + 1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_data  = r_data;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch controller feeding UART_TX one byte per frame.
//   state | meaning
//   IDLE  | waiting for a byte in the FIFO
//   LOAD  | popping the head byte onto o_tx_data_byte, arming the tick counter
//   START | o_tx_start high until START_TICKS baud ticks have been seen
//   WAIT  | waiting for a fresh rising edge on i_tx_done
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH  = 4,
    parameter int START_TICKS = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data_byte,
    input  logic                  i_tx_done,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_busy
);
    localparam int TICK_W = $clog2(START_TICKS + 1);

    feeder_state_t     r_state;
    feeder_state_t     w_state_next;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_done_prev;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic              w_done_rise;
    logic              w_full;
    logic              w_empty;

    assign w_push      = i_wr_valid && !w_full;
    assign w_pop       = (r_state == ST_LOAD);
    assign w_done_rise = i_tx_done && !r_done_prev;

    // The FIFO read register doubles as the byte presented to UART_TX: it only moves on a pop.
    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_wr_data),
        .o_data  (o_tx_data_byte),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_done_prev <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_done_prev <= i_tx_done;
            if (i_wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_state == ST_LOAD) begin
                r_tick_cnt <= TICK_W'(START_TICKS);
            end else if (r_state == ST_START && i_tick) begin
                r_tick_cnt <= r_tick_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_START;
            ST_START: if (i_tick && r_tick_cnt == TICK_W'(1)) w_state_next = ST_WAIT;
            ST_WAIT:  if (w_done_rise) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign o_tx_start = (r_state == ST_START);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_wr_ready = !w_full;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder; baud ticks and UART_TX done are driven by hand.
module tb_uart_tx_feeder;

    logic       i_clock    = 1'b0;
    logic       i_reset    = 1'b1;
    logic       i_tick     = 1'b0;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_data  = 8'h00;
    logic       i_tx_done  = 1'b0;
    logic       o_wr_ready;
    logic       o_tx_start;
    logic [7:0] o_tx_data_byte;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;
    int peak;
    logic seen_start;

    uart_tx_feeder dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tick         (i_tick),
        .i_wr_valid     (i_wr_valid),
        .i_wr_data      (i_wr_data),
        .o_wr_ready     (o_wr_ready),
        .o_tx_start     (o_tx_start),
        .o_tx_data_byte (o_tx_data_byte),
        .i_tx_done      (i_tx_done),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_busy         (o_busy)
    );

    always #100 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        i_wr_valid = 1'b1;
        i_wr_data  = b;
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic tick_pulse();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!o_tx_start && n < 40) begin
            step();
            n++;
        end
        chk(tag, o_tx_start, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] exp);
        wait_start("frame_start");
        chk("frame_data", o_tx_data_byte, exp);
        tick_pulse();
        tick_pulse();
        chk("frame_start_drop", o_tx_start, 1'b0);
        i_tx_done = 1'b1;
        step();
        chk("frame_idle", o_busy, 1'b0);
        i_tx_done = 1'b0;
        step();
    endtask

    task automatic apply_reset();
        i_reset = 1'b0;
        #20;
        i_reset = 1'b1;
        step();
    endtask

    initial begin
        // reset values
        #5 i_reset = 1'b0;
        #10;
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_ready", o_wr_ready, 1'b1);
        chk("rst_count", o_count, 5'd0);
        chk("rst_start", o_tx_start, 1'b0);
        chk("rst_data", o_tx_data_byte, 8'h00);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        step();
        i_reset = 1'b1;
        step();

        // 1: single byte, start two clocks after the write
        write_byte(8'hAA);
        chk("t1_count", o_count, 5'd1);
        chk("t1_start_e0", o_tx_start, 1'b0);
        step();
        chk("t1_start_e1", o_tx_start, 1'b0);
        chk("t1_busy_load", o_busy, 1'b1);
        step();
        chk("t1_start_e2", o_tx_start, 1'b1);
        chk("t1_data", o_tx_data_byte, 8'hAA);
        chk("t1_empty", o_empty, 1'b1);
        tick_pulse();
        chk("t1_start_tick1", o_tx_start, 1'b1);
        tick_pulse();
        chk("t1_start_tick2", o_tx_start, 1'b0);
        chk("t1_busy_wait", o_busy, 1'b1);
        i_tx_done = 1'b1;
        step();
        chk("t1_idle", o_busy, 1'b0);
        i_tx_done = 1'b0;
        step();
        chk("t1_data_hold", o_tx_data_byte, 8'hAA);

        // 2: burst of five bytes
        peak = 0;
        for (int b = 1; b <= 5; b++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'(b);
            step();
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        i_wr_valid = 1'b0;
        chk("t2_peak", 32'(peak), 32'd4);
        for (int b = 1; b <= 5; b++) send_frame(8'(b));
        chk("t2_empty", o_empty, 1'b1);
        chk("t2_busy", o_busy, 1'b0);
        chk("t2_count", o_count, 5'd0);

        // 3: fill with done held low; one byte is already in flight
        apply_reset();
        for (int b = 0; b < 17; b++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'(8'h10 + b);
            step();
        end
        i_wr_valid = 1'b0;
        chk("t3_full", o_full, 1'b1);
        chk("t3_ready", o_wr_ready, 1'b0);
        chk("t3_count", o_count, 5'd16);
        chk("t3_ovf_pre", o_overflow, 1'b0);
        write_byte(8'h21);
        chk("t3_ovf", o_overflow, 1'b1);
        chk("t3_count_drop", o_count, 5'd16);
        step(); step(); step();
        chk("t3_ovf_sticky", o_overflow, 1'b1);
        chk("t3_data", o_tx_data_byte, 8'h10);

        // 4: done edge and write in the same clock while full
        tick_pulse();
        tick_pulse();
        chk("t4_wait", o_tx_start, 1'b0);
        i_tx_done  = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = 8'h99;
        step();
        i_tx_done  = 1'b0;
        i_wr_valid = 1'b0;
        chk("t4_reject", o_count, 5'd16);
        chk("t4_idle", o_busy, 1'b0);
        step();
        chk("t4_load", o_count, 5'd16);
        step();
        chk("t4_pop", o_count, 5'd15);
        chk("t4_data", o_tx_data_byte, 8'h11);
        chk("t4_ready", o_wr_ready, 1'b1);
        write_byte(8'h77);
        chk("t4_refill", o_count, 5'd16);
        chk("t4_full", o_full, 1'b1);

        // 5: reset mid-frame, first with a full FIFO, then on the 8'h3C frame
        chk("t5_start_pre", o_tx_start, 1'b1);
        #30 i_reset = 1'b0;
        #1;
        chk("t5a_start", o_tx_start, 1'b0);
        chk("t5a_count", o_count, 5'd0);
        chk("t5a_empty", o_empty, 1'b1);
        chk("t5a_ovf", o_overflow, 1'b0);
        chk("t5a_busy", o_busy, 1'b0);
        @(negedge i_clock);
        i_reset = 1'b1;
        step();
        write_byte(8'h3C);
        step();
        step();
        chk("t5b_start", o_tx_start, 1'b1);
        chk("t5b_data", o_tx_data_byte, 8'h3C);
        tick_pulse();
        #30 i_reset = 1'b0;
        #1;
        chk("t5b_start_drop", o_tx_start, 1'b0);
        chk("t5b_count", o_count, 5'd0);
        chk("t5b_empty", o_empty, 1'b1);
        @(negedge i_clock);
        i_reset = 1'b1;
        step();
        seen_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            i_tick    = (c % 2 == 0);
            i_tx_done = (c % 5 == 0);
            step();
            if (o_tx_start) seen_start = 1'b1;
        end
        i_tick    = 1'b0;
        i_tx_done = 1'b0;
        chk("t5_no_frames", seen_start, 1'b0);

        // 6: stale done level must not end the frame
        apply_reset();
        i_tx_done = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("t6_idle", o_busy, 1'b0);
        write_byte(8'h5A);
        step();
        step();
        chk("t6_start", o_tx_start, 1'b1);
        chk("t6_data", o_tx_data_byte, 8'h5A);
        tick_pulse();
        tick_pulse();
        for (int c = 0; c < 5; c++) step();
        chk("t6_stale_done", o_busy, 1'b1);
        i_tx_done = 1'b0;
        step();
        chk("t6_low_done", o_busy, 1'b1);
        i_tx_done = 1'b1;
        step();
        chk("t6_fresh_done", o_busy, 1'b0);
        i_tx_done = 1'b0;
        seen_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            i_tick = (c % 2 == 0);
            step();
            if (o_tx_start) seen_start = 1'b1;
        end
        i_tick = 1'b0;
        chk("t6_single_frame", seen_start, 1'b0);
        chk("t6_empty", o_empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
